divider_7: RTL and testbench
============================

DIVIDER_7 -- requirements
Module: divider_7

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled on the rising edge of clk.
REQ-004 SHALL have port dividend, input, 17 bits, sign-magnitude: bit 16 is the sign (1 = negative); bits 15:0 are the magnitude.
REQ-005 SHALL have port divisor, input, 9 bits, sign-magnitude: bit 8 is the sign; bits 7:0 are the magnitude.
REQ-006 SHALL have port quot, output, 17 bits, sign-magnitude quotient: bit 16 is the sign; bits 15:0 are the magnitude.
REQ-007 SHALL have port rem, output, 9 bits, sign-magnitude remainder: bit 8 is the sign; bits 7:0 are the magnitude.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port rdy, output, 1 bit: one-cycle pulse marking that quot, rem and dbz have just updated.
REQ-010 SHALL have port dbz, output, 1 bit: divide-by-zero flag for the latest result.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE or DONE; on acceptance, SHALL register the dividend and divisor magnitudes and the two sign bits at that edge ("edge 0").
REQ-013 SHALL ignore start while in RUN; the in-flight operation and the registered operands SHALL be unaffected.
REQ-014 SHALL compute the magnitudes by restoring division, one quotient bit per cycle, MSB first: edges 1..16 produce quotient bits 15..0.
REQ-015 SHALL use a 9-bit partial remainder internally so that no overflow occurs for any divisor magnitude from 1 to 255.
REQ-016 SHALL load quot and rem and enter DONE at edge 16; rdy SHALL be high for exactly the cycle after edge 16.
REQ-017 SHALL drive busy high from the cycle after edge 0 through the cycle after edge 15, and low otherwise.
REQ-018 SHALL set the quotient sign to dividend[16] XOR divisor[8] and the remainder sign to dividend[16].
REQ-019 SHALL force any sign bit to 0 when the corresponding magnitude is 0, so that negative zero is never output.
REQ-020 SHALL, when the divisor magnitude is 0 at edge 0: skip RUN, go straight to DONE at edge 0, and load quot = 0_FFFF, rem = 0_00, dbz = 1, with rdy high for the following cycle.
REQ-021 SHALL clear dbz at the completion of any division with a non-zero divisor.
REQ-022 SHALL hold quot, rem and dbz stable from each completion until the next completion.
REQ-023 SHALL leave DONE for IDLE after one cycle unless start is high in that cycle.
REQ-024 SHALL, when start is high in DONE, begin the new operation at that edge (back-to-back operation) and still deliver the current rdy pulse.
REQ-025 SHALL use no combinational path from any input to any output.

Reset
REQ-026 SHALL, while rst_n = 0, asynchronously force: FSM = IDLE, quot = 0, rem = 0, busy = 0, rdy = 0, dbz = 0, and clear the internal counter and partial remainder.
REQ-027 SHALL, on reset asserted mid-RUN, abort the operation with no rdy pulse; the first start after release SHALL operate normally.

Verification
REQ-028 SHALL pass: dividend 0_03E8, divisor 0_07, start pulsed -> rdy 16 cycles after edge 0; quot 0_008E, rem 0_06, dbz 0.
REQ-029 SHALL pass: dividend 1_03E8, divisor 0_07 -> quot 1_008E, rem 1_06; and dividend 1_0005, divisor 1_07 -> quot 0_0000, rem 1_05.
REQ-030 SHALL pass: dividend 0_FFFF, divisor 0_01 -> quot 0_FFFF, rem 0_00; and divisor 0_FF -> quot 0_0101, rem 0_00.
REQ-031 SHALL pass: divisor 1_00 -> rdy in the cycle after edge 0, dbz 1, quot 0_FFFF; a following 0_0010 / 0_04 -> quot 0_0004, dbz 0.
REQ-032 SHALL pass: new operands pulsed on start at cycle 5 of RUN -> ignored, and the original result is delivered; start held high during DONE -> second result arrives 16 cycles later.
REQ-033 SHALL pass: rst_n low at cycle 8 of RUN -> all outputs 0 immediately (asynchronously), no rdy pulse; the next division completes correctly.

Source files
------------

// File: rtl/divider_7.sv
// Sequential sign-magnitude divider: 16-bit magnitude by 8-bit magnitude,
// restoring algorithm, one quotient bit per clock, MSB first.
module divider_7 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [16:0] dividend,
  input  logic [8:0]  divisor,
  output logic [16:0] quot,
  output logic [8:0]  rem,
  output logic        busy,
  output logic        rdy,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] dvd_q;
  logic [7:0]  dvs_q;
  logic [8:0]  prem_q;
  logic [3:0]  cnt_q;
  logic        sd_q;
  logic        sv_q;
  logic [16:0] quot_q;
  logic [8:0]  rem_q;
  logic        busy_q;
  logic        rdy_q;
  logic        dbz_q;

  logic [9:0]  trial;
  logic        qbit;
  logic [8:0]  prem_d;
  logic [15:0] dvd_d;
  logic        qsign;
  logic        rsign;
  logic        accept;
  logic        zero_dvs;
  logic        last;

  // Shift next dividend bit into the partial remainder and try a subtract.
  // The partial remainder stays below the divisor, so 9 bits never overflow.
  always_comb begin
    trial  = {prem_q, dvd_q[15]};
    qbit   = (trial >= {2'b00, dvs_q});
    prem_d = qbit ? 9'(trial - {2'b00, dvs_q}) : trial[8:0];
    dvd_d  = {dvd_q[14:0], qbit};
    qsign  = (sd_q ^ sv_q) & (|dvd_d);
    rsign  = sd_q & (|prem_d);
  end

  always_comb begin
    accept   = start & ((state_q == IDLE) | (state_q == DONE));
    zero_dvs = (divisor[7:0] == 8'd0);
    last     = (cnt_q == 4'd15);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (accept) begin
            dvd_q  <= dividend[15:0];
            dvs_q  <= divisor[7:0];
            sd_q   <= dividend[16];
            sv_q   <= divisor[8];
            prem_q <= '0;
            cnt_q  <= '0;
            if (zero_dvs) begin
              state_q <= DONE;
              rdy_q   <= 1'b1;
              dbz_q   <= 1'b1;
              quot_q  <= 17'h0FFFF;
              rem_q   <= '0;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_q  <= dvd_d;
          prem_q <= prem_d;
          cnt_q  <= cnt_q + 4'd1;
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            dbz_q   <= 1'b0;
            quot_q  <= {qsign, dvd_d};
            rem_q   <= {rsign, prem_d[7:0]};
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign busy = busy_q;
  assign rdy  = rdy_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_divider_7.sv
// Scoreboard bench for divider_7: stimulus pushes expected results,
// a negedge monitor pops and checks on every rdy pulse.
module tb_divider_7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] dividend = '0;
  logic [8:0]  divisor = '0;
  logic [16:0] quot;
  logic [8:0]  rem;
  logic        busy;
  logic        rdy;
  logic        dbz;

  typedef struct {
    logic [16:0] q;
    logic [8:0]  r;
    logic        z;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  divider_7 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quot     (quot),
    .rem      (rem),
    .busy     (busy),
    .rdy      (rdy),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_rdy", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("quot", 32'(quot), 32'(e.q));
          chk("rem", 32'(rem), 32'(e.r));
          chk("dbz", 32'(dbz), 32'(e.z));
          chk("rdy_cycle", cyc, e.c);
          chk("busy_at_rdy", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after edge 0.
  task automatic go(input logic [16:0] dd, input logic [8:0] dv,
                    input logic [16:0] eq, input logic [8:0] er,
                    input logic ez);
    exp_t e;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    e.q = eq;
    e.r = er;
    e.z = ez;
    e.c = cyc + (ez ? 0 : 16);
    sb.push_back(e);
    chk("busy_after_e0", 32'(busy), 32'(!ez));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rdy !== 1'b1) chk("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [16:0] dd, input logic [8:0] dv,
                     input logic [16:0] eq, input logic [8:0] er,
                     input logic ez);
    go(dd, dv, eq, er, ez);
    wait_rdy();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(17'h003E8, 9'h007, 17'h0008E, 9'h006, 1'b0);
    run(17'h103E8, 9'h007, 17'h1008E, 9'h106, 1'b0);
    run(17'h10005, 9'h107, 17'h00000, 9'h105, 1'b0);
    run(17'h0FFFF, 9'h001, 17'h0FFFF, 9'h000, 1'b0);
    run(17'h0FFFF, 9'h0FF, 17'h00101, 9'h000, 1'b0);
    run(17'h01234, 9'h100, 17'h0FFFF, 9'h000, 1'b1);
    run(17'h00010, 9'h004, 17'h00004, 9'h000, 1'b0);
    run(17'h10000, 9'h105, 17'h00000, 9'h000, 1'b0);
    run(17'h00007, 9'h103, 17'h10002, 9'h001, 1'b0);
    run(17'h10006, 9'h003, 17'h10002, 9'h000, 1'b0);
    run(17'h00003, 9'h005, 17'h00000, 9'h003, 1'b0);

    // Start during RUN must be ignored
    go(17'h00064, 9'h009, 17'h0000B, 9'h001, 1'b0);
    repeat (5) @(negedge clk);
    dividend = 17'h0FFFF;
    divisor  = 9'h001;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid_run", 32'(busy), 32'd1);
    wait_rdy();
    @(negedge clk);
    @(negedge clk);

    // Back-to-back: start high in DONE
    go(17'h000C8, 9'h00D, 17'h0000F, 9'h005, 1'b0);
    wait_rdy();
    go(17'h10100, 9'h010, 17'h10010, 9'h000, 1'b0);
    wait_rdy();
    @(negedge clk);
    @(negedge clk);

    // Reset mid-RUN: outputs clear at once, no rdy
    dividend = 17'h01234;
    divisor  = 9'h005;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_quot", 32'(quot), 32'd0);
    chk("arst_rem", 32'(rem), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rdy", 32'(rdy), 32'd0);
    chk("arst_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run(17'h00D07, 9'h00B, 17'h0012F, 9'h002, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
